// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle core's MEM stage: one request at a time, fixed wait states, one-cycle done pulse.
// Define DMEM_RESP_RANGE_CHK_EN to flag addresses beyond the word store as errors instead of wrapping.
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_done,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_done_q, rsp_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic          misaligned;
  logic          out_of_range;
  logic          acc_err;
  logic          mem_we;

  assign idx        = addr_q[AW+1:2];
  assign misaligned = |addr_q[1:0];

`ifdef DMEM_RESP_RANGE_CHK_EN
  assign out_of_range = |addr_q[31:AW+2];
`else
  // Upper address bits are deliberately dropped so accesses wrap modulo the store size.
  logic unused_addr_hi;
  assign out_of_range   = 1'b0;
  assign unused_addr_hi = ^addr_q[31:AW+2];
`endif

  assign acc_err = misaligned | out_of_range;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_done_d = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rsp_done_d = 1'b1;
        err_d      = acc_err;
        if (we_q) begin
          mem_we = ~acc_err;
        end else begin
          rdata_d = acc_err ? '0 : mem_q[idx];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_done_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_done_q <= rsp_done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Store contents are not reset; a write only happens from ACCESS, which reset always leaves.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_done  = rsp_done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, back-to-back, reset-abort and randomized traffic vs. an array model.
module tb_dmem_responder;

  localparam int unsigned W = 2;
  localparam int unsigned D = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem [D];
  logic [31:0] m_rdata = '0;

  dmem_responder #(.DEPTH(D), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_done  (rsp_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % D);
  endfunction

  function automatic bit err_of(input logic [31:0] a);
    bit e;
    e = (a % 4) != 0;
`ifdef DMEM_RESP_RANGE_CHK_EN
    if (a >= 4 * D) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       output bit e, output logic [31:0] rd);
    e = err_of(a);
    if (we) begin
      if (!e) m_mem[idx_of(a)] = wd;
    end else begin
      m_rdata = e ? 32'h0 : m_mem[idx_of(a)];
    end
    rd = m_rdata;
  endtask

  // Issues one request from IDLE and waits (bounded) for its done pulse; noise scribbles on inputs while busy.
  task automatic run_req(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit noise,
                         output logic [31:0] rd, output logic er);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk); #1;
    check("busy_after_accept", {30'd0, req_ready, busy}, 32'd1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (rsp_done) begin
        lat = i;
        break;
      end
    end
    req_valid = 1'b0;
    rd = rsp_rdata;
    er = rsp_err;
    check("done_latency", 32'(lat), 32'(W + 1));
    @(posedge clk); #1;
    check("done_single_pulse", {31'd0, rsp_done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er;
    bit          exp_e;
    int          pulses;
    int          stray;

    tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h13,  32'h12345678, 1'b1, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 32'h11,  32'h0,        1'b1, 1'b1, 32'h0};
`ifdef DMEM_RESP_RANGE_CHK_EN
    tbl[5] = '{1'b1, 32'h400, 32'h1,        1'b1, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 32'hC0DE0000};
`else
    tbl[5] = '{1'b1, 32'h400, 32'h1,        1'b0, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 32'h1};
`endif
    tbl[7] = '{1'b1, 32'h20,  32'h0BADF00D, 1'b0, 1'b0, 32'h0};
    tbl[8] = '{1'b0, 32'h20,  32'h0,        1'b0, 1'b1, 32'h0BADF00D};

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done",  {31'd0, rsp_done},  32'd0);
    check("rst_err",   {31'd0, rsp_err},   32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rdata", rsp_rdata,          32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Give every word a known value
    for (int i = 0; i < int'(D); i++) begin
      run_req(1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 1'b0, rd, er);
      model(1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i), exp_e, exp_rd);
      check("fill_err", {31'd0, er}, {31'd0, exp_e});
    end

    // Directed vectors
    for (int k = 0; k < 9; k++) begin
      run_req(tbl[k].we, tbl[k].addr, tbl[k].wdata, 1'b0, rd, er);
      model(tbl[k].we, tbl[k].addr, tbl[k].wdata, exp_e, exp_rd);
      check($sformatf("vec%0d_err", k), {31'd0, er}, {31'd0, tbl[k].exp_err});
      if (tbl[k].chk_rd) check($sformatf("vec%0d_rdata", k), rd, tbl[k].exp_rd);
    end

    // req_valid held high: accepts at E0 and E5, done at E3 and E8 only
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk); #1;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (rsp_done) pulses++;
      if (i == 3 || i == 8) begin
        check($sformatf("b2b_done_e%0d", i), {31'd0, rsp_done}, 32'd1);
        check($sformatf("b2b_rdata_e%0d", i), rsp_rdata, 32'hDEADBEEF);
      end
      if (i == 4) check("b2b_idle_e4", {30'd0, req_ready, busy}, 32'd2);
      if (i == 5) check("b2b_reaccept_e5", {31'd0, busy}, 32'd1);
    end
    req_valid = 1'b0;
    model(1'b0, 32'h10, 32'h0, exp_e, exp_rd);
    model(1'b0, 32'h10, 32'h0, exp_e, exp_rd);
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_final_idle", {31'd0, busy}, 32'd0);

    // Reset during WAIT of a store: aborted, no done pulse
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_busy_wait", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_async_idle", {30'd0, req_ready, busy}, 32'd2);
    check("abort_no_done", {31'd0, rsp_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_rdata = '0;
    check("abort_rdata_cleared", rsp_rdata, 32'd0);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_done) stray++;
    end
    check("abort_stray_done", 32'(stray), 32'd0);
    run_req(1'b0, 32'h20, 32'h0, 1'b0, rd, er);
    model(1'b0, 32'h20, 32'h0, exp_e, exp_rd);
    check("abort_load_prior", rd, 32'h0BADF00D);
    check("abort_load_err", {31'd0, er}, 32'd0);

    // Randomized traffic against the array model
    for (int n = 0; n < 200; n++) begin
      bit          we;
      int unsigned sel;
      logic [31:0] a;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = 32'($urandom_range(0, D - 1) * 4);
      else if (sel < 8) a = 32'($urandom_range(0, D - 1) * 4 + $urandom_range(1, 3));
      else              a = $urandom;
      wd = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_req(we, a, wd, 1'b1, rd, er);
      model(we, a, wd, exp_e, exp_rd);
      check($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, exp_e});
      check($sformatf("rnd%0d_rdata", n), rd, exp_rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
